// File: rtl/cu_pkg.sv
// Shared encodings for the control-unit sequencer and the downstream output decoder.
// Both blocks import this package, so state and opcode values cannot drift apart.
package cu_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_WB   = 3'b011,
      S_MEM  = 3'b100,
      S_HALT = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SLTI = 6'b100111;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_BNE  = 6'b110101;
   localparam logic [5:0] OP_BGTZ = 6'b110110;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [2:0] {
      C_ALU,
      C_MEM,
      C_BR,
      C_JMP,
      C_HALT,
      C_UNDEF
   } iclass_t;

   function automatic iclass_t op_class(input logic [5:0] op);
      iclass_t c;
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
         OP_ORI, OP_SLL, OP_SLT, OP_SLTI:  c = C_ALU;
         OP_SW, OP_LW:                     c = C_MEM;
         OP_BEQ, OP_BNE, OP_BGTZ:          c = C_BR;
         OP_J, OP_JR, OP_JAL:              c = C_JMP;
         OP_HALT:                          c = C_HALT;
         default:                          c = C_UNDEF;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cu_state_sequencer_if.sv
// Sequencer bus: instruction/memory inputs toward the sequencer, state and debug status back.
interface cu_state_sequencer_if #(
   parameter int CNT_W = 32
);
   // MemReady is a level-sampled ready: it is only looked at while State is sMEM, and a
   // cycle with MemReady=1 there completes the access at that clock edge; MemReady=0 stalls.
   logic [5:0]       Opcode;
   logic             MemReady;
   logic [2:0]       State;
   logic             InstrDone;
   logic             Halted;
   logic             IllegalOp;
   logic [CNT_W-1:0] RetireCount;
   logic [CNT_W-1:0] CycleCount;

   modport master (
      output Opcode, MemReady,
      input  State, InstrDone, Halted, IllegalOp, RetireCount, CycleCount
   );

   modport slave (
      input  Opcode, MemReady,
      output State, InstrDone, Halted, IllegalOp, RetireCount, CycleCount
   );
endinterface

// File: rtl/cu_next_state.sv
// Combinational next-state logic: picks the successor state from opcode class and
// MemReady, and flags completion edges and undefined-opcode decodes.
module cu_next_state
   import cu_pkg::*;
(
   input  logic [2:0] i_state,
   input  logic [5:0] i_opcode,
   input  logic       i_mem_ready,
   output state_t     o_next_state,
   output logic       o_complete,
   output logic       o_illegal
);

   iclass_t w_class;

   assign w_class = op_class(i_opcode);

   always_comb begin
      o_next_state = S_IF;
      o_complete   = 1'b0;
      o_illegal    = 1'b0;
      case (i_state)
         S_IF: begin
            o_next_state = S_ID;
         end
         S_ID: begin
            case (w_class)
               C_ALU, C_MEM, C_BR: o_next_state = S_EXE;
               C_JMP: begin
                  o_next_state = S_IF;
                  o_complete   = 1'b1;
               end
               C_HALT: begin
                  o_next_state = S_HALT;
                  o_complete   = 1'b1;
               end
               default: begin
                  // Undefined opcode retires as a nop and raises the sticky flag.
                  o_next_state = S_IF;
                  o_complete   = 1'b1;
                  o_illegal    = 1'b1;
               end
            endcase
         end
         S_EXE: begin
            case (w_class)
               C_ALU:   o_next_state = S_WB;
               C_MEM:   o_next_state = S_MEM;
               default: begin
                  o_next_state = S_IF;
                  o_complete   = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            if (!i_mem_ready) begin
               o_next_state = S_MEM;
            end else if (i_opcode == OP_LW) begin
               o_next_state = S_WB;
            end else begin
               o_next_state = S_IF;
               o_complete   = 1'b1;
            end
         end
         S_WB: begin
            o_next_state = S_IF;
            o_complete   = 1'b1;
         end
         S_HALT: begin
            o_next_state = S_HALT;
         end
         default: begin
            // 101/110 recover quietly to fetch with no completion or flag.
            o_next_state = S_IF;
         end
      endcase
   end

endmodule

// File: rtl/cu_state_sequencer.sv
// Multi-cycle control-unit sequencer: state register, InstrDone pulse, sticky
// illegal-opcode flag and retire/cycle debug counters.
module cu_state_sequencer
   import cu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic                  CLK,
   input logic                  Reset,
   cu_state_sequencer_if.slave  bus
);

   logic [2:0]       r_state;
   logic             r_instr_done;
   logic             r_illegal;
   logic [CNT_W-1:0] r_retire;
   logic [CNT_W-1:0] r_cycle;

   state_t           w_next_state;
   logic             w_complete;
   logic             w_illegal;

   cu_next_state u_next_state (
      .i_state      (r_state),
      .i_opcode     (bus.Opcode),
      .i_mem_ready  (bus.MemReady),
      .o_next_state (w_next_state),
      .o_complete   (w_complete),
      .o_illegal    (w_illegal)
   );

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IF;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_instr_done <= 1'b0;
         r_illegal    <= 1'b0;
         r_retire     <= '0;
         r_cycle      <= '0;
      end else begin
         r_instr_done <= w_complete;
         r_illegal    <= r_illegal | w_illegal;
         if (w_complete) begin
            r_retire <= r_retire + CNT_W'(1);
         end
         // The entry edge into sHALT still counts; only cycles spent in sHALT are frozen.
         if (r_state != S_HALT) begin
            r_cycle <= r_cycle + CNT_W'(1);
         end
      end
   end

   assign bus.State       = r_state;
   assign bus.InstrDone   = r_instr_done;
   assign bus.Halted      = (r_state == S_HALT);
   assign bus.IllegalOp   = r_illegal;
   assign bus.RetireCount = r_retire;
   assign bus.CycleCount  = r_cycle;

endmodule

// File: tb/tb_cu_state_sequencer.sv
// Bench for cu_state_sequencer: directed scenarios plus random instruction streams,
// checked against a per-instruction state-trace model.
module tb_cu_state_sequencer;

   localparam int CW = 8;

   logic clk;
   logic rst;

   cu_state_sequencer_if #(.CNT_W(CW)) bus ();

   cu_state_sequencer #(.CNT_W(CW)) dut (
      .CLK   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int exp_retire;
   int exp_cycle;
   bit exp_done;
   bit exp_illegal;

   logic [5:0] defined_ops [17] = '{
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
      6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
      6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010
   };

   // 0 ALU, 1 SW, 2 LW, 3 BR, 4 JMP, 5 HALT, 6 UNDEF
   function automatic int kind_of(input logic [5:0] op);
      int k;
      k = 6;
      for (int i = 0; i < 9; i++) if (defined_ops[i] == op) k = 0;
      if (op == 6'b110000) k = 1;
      if (op == 6'b110001) k = 2;
      if (op == 6'b110100 || op == 6'b110101 || op == 6'b110110) k = 3;
      if (op == 6'b111000 || op == 6'b111001 || op == 6'b111010) k = 4;
      if (op == 6'b111111) k = 5;
      return k;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input int st);
      chk("state", 32'(bus.State), 32'(st));
      chk("instr_done", 32'(bus.InstrDone), 32'(exp_done));
      chk("halted", 32'(bus.Halted), 32'(st == 7));
      chk("illegal_op", 32'(bus.IllegalOp), 32'(exp_illegal));
      chk("retire_count", 32'(bus.RetireCount), 32'(exp_retire % 256));
      chk("cycle_count", 32'(bus.CycleCount), 32'(exp_cycle % 256));
   endtask

   // Called at a negedge; returns at the negedge with reset just released.
   task automatic do_reset();
      rst = 1'b1;
      #2;
      chk("rst_state", 32'(bus.State), 32'd0);
      chk("rst_done", 32'(bus.InstrDone), 32'd0);
      chk("rst_halted", 32'(bus.Halted), 32'd0);
      chk("rst_illegal", 32'(bus.IllegalOp), 32'd0);
      chk("rst_retire", 32'(bus.RetireCount), 32'd0);
      chk("rst_cycle", 32'(bus.CycleCount), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_retire  = 0;
      exp_cycle   = 0;
      exp_done    = 0;
      exp_illegal = 0;
   endtask

   // Runs one instruction from sIF back to sIF (or into sHALT). abort_k >= 0 fires an
   // asynchronous reset mid-cycle at that trace position instead of finishing.
   task automatic run_instr(input logic [5:0] op, input int stalls, input int abort_k);
      int tr[$];
      int kind;
      int mem_i;
      kind  = kind_of(op);
      mem_i = 0;
      tr.push_back(0);
      tr.push_back(1);
      if (kind <= 3) tr.push_back(2);
      if (kind == 0) tr.push_back(3);
      if (kind == 1 || kind == 2) for (int i = 0; i <= stalls; i++) tr.push_back(4);
      if (kind == 2) tr.push_back(3);
      for (int k = 0; k < tr.size(); k++) begin
         check_outputs(tr[k]);
         if (k == abort_k) begin
            #2 rst = 1'b1;
            #1;
            chk("abort_state", 32'(bus.State), 32'd0);
            chk("abort_done", 32'(bus.InstrDone), 32'd0);
            chk("abort_retire", 32'(bus.RetireCount), 32'd0);
            chk("abort_cycle", 32'(bus.CycleCount), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            exp_retire = 0; exp_cycle = 0; exp_done = 0; exp_illegal = 0;
            return;
         end
         bus.Opcode = (tr[k] == 0) ? 6'($urandom_range(0, 63)) : op;
         if (tr[k] == 4) begin
            bus.MemReady = (mem_i >= stalls);
            mem_i++;
         end else begin
            bus.MemReady = 1'($urandom_range(0, 1));
         end
         exp_cycle++;
         if (k == tr.size() - 1) begin
            exp_retire++;
            exp_done = 1;
            if (kind == 6) exp_illegal = 1;
         end else begin
            exp_done = 0;
         end
         @(negedge clk);
      end
      if (kind == 5) begin
         for (int i = 0; i < 20; i++) begin
            check_outputs(7);
            bus.Opcode   = 6'($urandom_range(0, 63));
            bus.MemReady = 1'($urandom_range(0, 1));
            exp_done = 0;
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op;
      rst = 1'b1;
      bus.Opcode = 6'd0;
      bus.MemReady = 1'b0;
      exp_retire = 0; exp_cycle = 0; exp_done = 0; exp_illegal = 0;
      @(negedge clk);
      do_reset();

      run_instr(6'b000000, 0, -1);  // add
      run_instr(6'b110001, 3, -1);  // lw with 3 stall cycles
      run_instr(6'b110100, 0, -1);  // beq
      run_instr(6'b111010, 0, -1);  // jal
      run_instr(6'b101010, 0, -1);  // undefined
      run_instr(6'b000000, 0, -1);  // add, IllegalOp must stay set
      run_instr(6'b110000, 1, -1);  // sw with one stall

      @(negedge clk);
      do_reset();
      run_instr(6'b111111, 0, -1);  // halt, then 20 frozen cycles
      do_reset();

      run_instr(6'b110000, 3, 4);   // sw aborted mid-sMEM by async reset

      for (int n = 0; n < 90; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            op = 6'($urandom_range(0, 63));
            while (kind_of(op) != 6) op = 6'($urandom_range(0, 63));
         end else begin
            op = defined_ops[$urandom_range(0, 16)];
         end
         run_instr(op, int'($urandom_range(0, 3)), -1);
      end
      check_outputs(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
